// File: rtl/LoaderCommandPackage.sv
// LoaderCommandPackage: serial loader opcodes, response bytes and FSM state encoding.
package LoaderCommandPackage;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_GO    = 8'h47;
  localparam logic [7:0] CMD_HALT  = 8'h48;
  localparam logic [7:0] ACK       = 8'h06;
  localparam logic [7:0] NAK       = 8'h15;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_WRITE,
    ST_READ_WAIT,
    ST_SEND
  } loader_state_e;
endpackage

// File: rtl/MemoryModesPackage.sv
// MemoryModesPackage: memory port access-mode encodings shared with the memory system.
package MemoryModesPackage;
  typedef enum logic [2:0] {
    MEM_NONE = 3'd0,
    MEM_BYTE = 3'd1,
    MEM_HALF = 3'd2,
    MEM_WORD = 3'd3
  } mem_mode_e;
endpackage

// File: rtl/serial_memory_loader_if.sv
// serial_memory_loader_if: byte stream, processor control and memory port of the serial loader.
interface serial_memory_loader_if;
  import MemoryModesPackage::*;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic        tx_ready;
  logic        pause;
  logic        external_memory_control;
  logic [31:0] external_address;
  logic [31:0] external_data;
  mem_mode_e   external_read_mode;
  mem_mode_e   external_write_mode;
  logic [31:0] external_data_out;
  modport master (
    input  rx_valid, rx_byte, tx_ready, external_data_out,
    output tx_valid, tx_byte, pause, external_memory_control,
           external_address, external_data, external_read_mode, external_write_mode
  );
  modport slave (
    output rx_valid, rx_byte, tx_ready, external_data_out,
    input  tx_valid, tx_byte, pause, external_memory_control,
           external_address, external_data, external_read_mode, external_write_mode
  );
endinterface

// File: rtl/loader_timeout_counter.sv
// loader_timeout_counter: saturating idle counter, expired once TIMEOUT_CYCLES enabled cycles pass without clear.
module loader_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign expired = cnt_q == W'(TIMEOUT_CYCLES);
  always_comb cnt_d = clear ? '0 : (enable && !expired) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/serial_memory_loader.sv
// serial_memory_loader: decodes serial command frames into word reads/writes on the memory port
// and returns ACK/NAK or read data over the byte transmitter.
module serial_memory_loader
  import MemoryModesPackage::*;
  import LoaderCommandPackage::*;
#(
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic                   clk,
  input logic                   rst_n,
  serial_memory_loader_if.master bus
);
  localparam int LW = READ_LATENCY > 1 ? $clog2(READ_LATENCY) : 1;
  loader_state_e state_q, state_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic          is_read_q, is_read_d;
  logic [31:0]   addr_q, addr_d, data_q, data_d, resp_q, resp_d;
  logic [2:0]    tx_left_q, tx_left_d;
  logic          hold_q, hold_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          in_frame, expired, is_mem_op, is_ctl_op;
  assign in_frame  = state_q == ST_ADDR || state_q == ST_DATA;
  assign is_mem_op = bus.rx_byte == CMD_WRITE || bus.rx_byte == CMD_READ;
  assign is_ctl_op = bus.rx_byte == CMD_GO || bus.rx_byte == CMD_HALT;
  loader_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!in_frame || bus.rx_valid),
    .enable  (in_frame),
    .expired (expired)
  );
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    is_read_d  = is_read_q;
    addr_d     = addr_q;
    data_d     = data_q;
    resp_d     = resp_q;
    tx_left_d  = tx_left_q;
    hold_d     = hold_q;
    lat_d      = '0;
    case (state_q)
      ST_IDLE: if (bus.rx_valid) begin
        is_read_d  = bus.rx_byte == CMD_READ;
        byte_cnt_d = '0;
        state_d    = is_mem_op ? ST_ADDR : ST_SEND;
        tx_left_d  = 3'd1;
        resp_d     = is_mem_op ? resp_q : {is_ctl_op ? ACK : NAK, 24'h0};
        hold_d     = bus.rx_byte == CMD_GO ? 1'b0 : (is_mem_op || bus.rx_byte == CMD_HALT) ? 1'b1 : hold_q;
      end
      ST_ADDR, ST_DATA: if (bus.rx_valid) begin
        byte_cnt_d = byte_cnt_q + 2'd1;
        addr_d     = state_q == ST_ADDR ? {addr_q[23:0], bus.rx_byte} : addr_q;
        data_d     = state_q == ST_DATA ? {data_q[23:0], bus.rx_byte} : data_q;
        if (byte_cnt_q == 2'd3)
          state_d = state_q == ST_DATA ? ST_WRITE : is_read_q ? ST_READ_WAIT : ST_DATA;
      end else if (expired) begin
        // abandoned frame: NAK without touching memory
        state_d   = ST_SEND;
        resp_d    = {NAK, 24'h0};
        tx_left_d = 3'd1;
      end
      ST_WRITE: begin
        state_d   = ST_SEND;
        resp_d    = {ACK, 24'h0};
        tx_left_d = 3'd1;
      end
      ST_READ_WAIT: if (lat_q == LW'(READ_LATENCY - 1)) begin
        state_d   = ST_SEND;
        resp_d    = bus.external_data_out;
        tx_left_d = 3'd4;
      end else lat_d = lat_q + 1'b1;
      ST_SEND: if (bus.tx_ready) begin
        resp_d    = {resp_q[23:0], 8'h0};
        tx_left_d = tx_left_q - 3'd1;
        state_d   = tx_left_q == 3'd1 ? ST_IDLE : ST_SEND;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      is_read_q  <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      resp_q     <= '0;
      tx_left_q  <= '0;
      hold_q     <= 1'b1;
      lat_q      <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      is_read_q  <= is_read_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      resp_q     <= resp_d;
      tx_left_q  <= tx_left_d;
      hold_q     <= hold_d;
      lat_q      <= lat_d;
    end
  assign bus.tx_valid                = state_q == ST_SEND;
  assign bus.tx_byte                 = resp_q[31:24];
  assign bus.pause                   = hold_q;
  assign bus.external_memory_control = hold_q;
  assign bus.external_address        = addr_q;
  assign bus.external_data           = data_q;
  assign bus.external_read_mode      = state_q == ST_READ_WAIT ? MEM_WORD : MEM_NONE;
  assign bus.external_write_mode     = state_q == ST_WRITE ? MEM_WORD : MEM_NONE;
endmodule

// File: tb/tb_serial_memory_loader.sv
// tb_serial_memory_loader: directed and randomized frames checked against a word-level memory model.
module tb_serial_memory_loader;
  import MemoryModesPackage::*;
  import LoaderCommandPackage::*;
  localparam int RL  = 2;
  localparam int TMO = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  serial_memory_loader_if bus();
  serial_memory_loader #(.READ_LATENCY(RL), .TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0, wr_count = 0, rd_cycles = 0, both_cnt = 0, rd_age = 0;
  logic [31:0] wr_addr, wr_data;
  logic pause_at_read;
  bit prev_rd = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [7:0] rxq [$];
  logic [31:0] pool [4];
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction
  function automatic logic [7:0] got(input int i);
    return i < rxq.size() ? rxq[i] : 8'hxx;
  endfunction
  // memory returns valid data only after RL-1 clocks of read mode
  assign bus.external_data_out = (bus.external_read_mode == MEM_WORD && rd_age >= RL - 1)
                                 ? mem_rd(bus.external_address) : 32'hDEAD_BEEF;
  always @(posedge clk) rd_age <= bus.external_read_mode == MEM_WORD ? rd_age + 1 : 0;
  always @(negedge clk) begin
    if (bus.external_write_mode == MEM_WORD) begin
      wr_count++;
      wr_addr = bus.external_address;
      wr_data = bus.external_data;
      mem[bus.external_address] = bus.external_data;
    end
    if (bus.external_read_mode == MEM_WORD) begin
      if (!prev_rd) pause_at_read = bus.pause;
      rd_cycles++;
    end
    if (bus.external_read_mode != MEM_NONE && bus.external_write_mode != MEM_NONE) both_cnt++;
    prev_rd = bus.external_read_mode == MEM_WORD;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_pause"}, 32'(bus.pause), 1);
    check({tag, "_ctrl"}, 32'(bus.external_memory_control), 1);
    check({tag, "_addr"}, bus.external_address, 0);
    check({tag, "_data"}, bus.external_data, 0);
    check({tag, "_rmode"}, 32'(bus.external_read_mode), 32'(MEM_NONE));
    check({tag, "_wmode"}, 32'(bus.external_write_mode), 32'(MEM_NONE));
    check({tag, "_txv"}, 32'(bus.tx_valid), 0);
    check({tag, "_txb"}, 32'(bus.tx_byte), 0);
  endtask
  task automatic send(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask
  task automatic send32(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send(w[i*8 +: 8]);
  endtask
  task automatic collect(input int n, input bit toggle);
    int waitc, tries;
    logic [7:0] held;
    bit rdy;
    rxq.delete();
    for (int i = 0; i < n; i++) begin
      waitc = 0;
      while (bus.tx_valid !== 1'b1 && waitc < 100) begin
        @(negedge clk);
        waitc++;
      end
      if (bus.tx_valid !== 1'b1) begin
        check("tx_timeout", 32'(bus.tx_valid), 1);
        return;
      end
      held  = bus.tx_byte;
      tries = 0;
      do begin
        rdy = !toggle || tries >= 6 || (tries > 0 && $urandom_range(0, 1) == 1);
        bus.tx_ready = rdy;
        @(negedge clk);
        tries++;
        if (!rdy) begin
          check("tx_hold_valid", 32'(bus.tx_valid), 1);
          check("tx_hold_byte", 32'(bus.tx_byte), 32'(held));
        end
      end while (!rdy);
      bus.tx_ready = 1'b0;
      rxq.push_back(held);
    end
  endtask
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input bit toggle);
    int w0;
    w0 = wr_count;
    send(CMD_WRITE);
    send32(a);
    send32(d);
    collect(1, toggle);
    check("w_ack", 32'(got(0)), 32'(ACK));
    check("w_count", 32'(wr_count - w0), 1);
    check("w_addr", wr_addr, a);
    check("w_data", wr_data, d);
    check("w_pause", 32'(bus.pause), 1);
    check("w_ctrl", 32'(bus.external_memory_control), 1);
    check("w_txidle", 32'(bus.tx_valid), 0);
    ref_mem[a] = d;
  endtask
  task automatic do_read(input logic [31:0] a, input bit toggle);
    int w0, r0;
    w0 = wr_count;
    r0 = rd_cycles;
    send(CMD_READ);
    send32(a);
    collect(4, toggle);
    check("r_data", {got(0), got(1), got(2), got(3)}, ref_rd(a));
    check("r_lat", 32'(rd_cycles - r0), RL);
    check("r_nowrite", 32'(wr_count - w0), 0);
    check("r_txidle", 32'(bus.tx_valid), 0);
  endtask
  task automatic do_cmd(input logic [7:0] op, input logic [7:0] resp, input logic exp_pause);
    int w0, r0;
    w0 = wr_count;
    r0 = rd_cycles;
    send(op);
    collect(1, 1'b0);
    check("c_resp", 32'(got(0)), 32'(resp));
    check("c_pause", 32'(bus.pause), 32'(exp_pause));
    check("c_ctrl", 32'(bus.external_memory_control), 32'(exp_pause));
    check("c_nomem", 32'((wr_count - w0) + (rd_cycles - r0)), 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int w0, c;
    logic [31:0] a, d;
    logic [7:0] op;
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
    bus.tx_ready = 1'b0;
    pool[0] = 32'h0000_0400;
    pool[1] = 32'h0000_FFFC;
    pool[2] = 32'h0000_0080;
    pool[3] = $urandom;
    repeat (2) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);
    do_write(32'h0000_0400, 32'h0800_3FFB, 1'b0);
    do_read(32'h0000_0400, 1'b1);
    check("vec_bytes", {got(0), got(1), got(2), got(3)}, 32'h0800_3FFB);
    do_cmd(CMD_GO, ACK, 1'b0);
    pause_at_read = 1'bx;
    do_read(32'h0000_FFFC, 1'b0);
    check("pause_before_read", 32'(pause_at_read), 1);
    do_cmd(CMD_GO, ACK, 1'b0);
    do_cmd(CMD_HALT, ACK, 1'b1);
    do_cmd(8'h5A, NAK, 1'b1);
    w0 = wr_count;
    send(CMD_WRITE);
    send(8'h00);
    send(8'h00);
    c = 0;
    while (bus.tx_valid !== 1'b1 && c < 40) begin
      @(negedge clk);
      c++;
    end
    check("tmo_window", 32'(c >= TMO && c <= TMO + 2), 1);
    collect(1, 1'b0);
    check("tmo_nak", 32'(got(0)), 32'(NAK));
    check("tmo_nowrite", 32'(wr_count - w0), 0);
    check("tmo_pause", 32'(bus.pause), 1);
    w0 = wr_count;
    a = 32'h0000_0080;
    d = 32'h1234_5678;
    send(CMD_WRITE);
    for (int i = 7; i >= 0; i--) begin
      repeat (TMO - 1) @(negedge clk);
      send(i >= 4 ? a[(i-4)*8 +: 8] : d[i*8 +: 8]);
    end
    collect(1, 1'b0);
    check("gap_ack", 32'(got(0)), 32'(ACK));
    check("gap_write", 32'(wr_count - w0), 1);
    check("gap_data", wr_data, d);
    ref_mem[a] = d;
    for (int i = 0; i < 10; i++) begin
      a = pool[$urandom_range(0, 3)];
      case ($urandom_range(0, 2))
        0: do_write(a, $urandom, 1'($urandom_range(0, 1)));
        1: do_read(a, 1'($urandom_range(0, 1)));
        default: begin
          op = 8'($urandom_range(0, 255));
          if (op != CMD_WRITE && op != CMD_READ && op != CMD_GO && op != CMD_HALT) do_cmd(op, NAK, 1'b1);
          else do_read(a, 1'b1);
        end
      endcase
    end
    w0 = wr_count;
    send(CMD_WRITE);
    send32(32'h0000_0010);
    send(8'hAA);
    #2 rst_n = 1'b0;
    #1 check_reset("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_nowrite", 32'(wr_count - w0), 0);
    check("midrst_idle_tx", 32'(bus.tx_valid), 0);
    do_write(32'h0000_0010, 32'hCAFE_F00D, 1'b1);
    do_read(32'h0000_0010, 1'b1);
    check("mode_overlap", 32'(both_cnt), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/serial_memory_loader.md
SERIAL_MEMORY_LOADER -- requirements
Module: serial_memory_loader

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 1: clocks from read-mode assertion to valid externalDataOut.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000: inter-byte idle limit inside a frame.
REQ-003 SHALL have a single clock and an asynchronous, active-low reset: clk input 1 (all logic on rising edge); rst input 1 (asynchronous, active-low).
REQ-004 rxValid  input  1  received byte strobe, one cycle per byte.
REQ-005 rxByte  input  8  received byte, valid with rxValid.
REQ-006 txValid  output  1  response byte available.
REQ-007 txByte  output  8  response byte.
REQ-008 txReady  input  1  transmitter accepts txByte when high with txValid.
REQ-009 pause  output  1  halts processor.
REQ-010 externalMemoryControl  output  1  gives memory port to this block.
REQ-011 externalAddress  output  32  memory byte address.
REQ-012 externalData  output  32  write data.
REQ-013 externalReadMode  output  3  MemoryModesPackage mode; NONE or WORD only.
REQ-014 externalWriteMode  output  3  MemoryModesPackage mode; NONE or WORD only.
REQ-015 externalDataOut  input  32  memory read data.

Function
REQ-016 Frames: first byte is opcode; all multi-byte fields SHALL be big-endian (MSB first).
REQ-017 'W' (0x57) + 4 addr + 4 data SHALL write one word, then send ACK 0x06.
REQ-018 'R' (0x52) + 4 addr SHALL read one word, then send the 4 data bytes MSB first, with no ACK.
REQ-019 'G' (0x47) SHALL drive pause=0 and externalMemoryControl=0, then send ACK.
REQ-020 'H' (0x48) SHALL drive pause=1 and externalMemoryControl=1, then send ACK.
REQ-021 Any other opcode SHALL send NAK 0x15 and return to IDLE.
REQ-022 States: IDLE, ADDR, DATA, WRITE, READ_WAIT, SEND, IDLE.
- IDLE -> ADDR on rxValid with W or R.
- ADDR -> DATA (W) or READ_WAIT (R) after 4th byte.
- DATA -> WRITE after 4th byte.
- WRITE -> SEND after 1 cycle.
- READ_WAIT -> SEND after READ_LATENCY cycles.
- SEND -> IDLE after the last byte is accepted.
REQ-023 On entering ADDR, the block SHALL set pause=1 and externalMemoryControl=1; these remain set after the frame completes.
REQ-024 WRITE SHALL assert externalWriteMode=WORD for exactly one clock with stable address and data; externalReadMode=NONE.
REQ-025 READ_WAIT SHALL hold externalReadMode=WORD and capture externalDataOut on its final cycle; externalWriteMode=NONE.
REQ-026 Outside WRITE and READ_WAIT, both modes SHALL be NONE.
REQ-027 txValid/txByte SHALL hold stable until txReady is high on a rising edge; the next byte is presented the following cycle at the earliest.
REQ-028 rxValid in SEND, WRITE or READ_WAIT SHALL be dropped; no buffering.
REQ-029 If TIMEOUT_CYCLES elapse without rxValid while in ADDR or DATA, the block SHALL send NAK and return to IDLE with no memory access; pause is unchanged.
REQ-030 The timeout counter SHALL reset on every accepted byte and saturate rather than wrap.
REQ-031 Address and data SHALL be accepted as sent; no alignment check is performed.

Reset
REQ-032 Reset values:
- pause=1, externalMemoryControl=1.
- externalAddress=0, externalData=0.
- both modes=NONE.
- txValid=0, txByte=0.
- state=IDLE, counters=0.
REQ-033 Reset asserted mid-frame SHALL abort immediately; the partial frame is discarded and no write is issued.

Structure
REQ-034 Command bytes, ACK/NAK constants and the state enum SHALL live in a shared package, LoaderCommandPackage; mode encodings come from MemoryModesPackage.
REQ-035 The timeout counter SHALL be a sub-module, loader_timeout_counter (inputs: clear, enable; output: expired).

Verification
REQ-036 Bytes 57 00 00 04 00 08 00 3F FB -> one-cycle WORD write at 0x400 with data 0x08003FFB; ACK 0x06.
REQ-037 Bytes 52 00 00 04 00 -> tx bytes 08 00 3F FB, with txReady toggled to prove holding.
REQ-038 Bytes 47 -> pause=0, externalMemoryControl=0, ACK; then 52 00 00 FF FC -> pause=1 before the read begins.
REQ-039 Byte 5A -> NAK 0x15, no mode change; 57 00 00 then idle (TIMEOUT_CYCLES=16) -> NAK after 16 cycles, no write.
REQ-040 Reset pulse after 6 bytes of a W frame -> all outputs at reset values, no WriteMode=WORD observed; the next full frame works.
